// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared FSM encoding, AXI constants and owner type for the cache read arbiter.
package cache_axi_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;
    localparam logic [3:0] ID_I_DEF = 4'd0;
    localparam logic [3:0] ID_D_DEF = 4'd1;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
endpackage

// File: rtl/cache_rd_arb_pick.sv
// cache_rd_arb_pick: 2-way picker; req/gnt bit0 = I-cache, bit1 = D-cache; ties go to the side that did not own last.
module cache_rd_arb_pick
    import cache_axi_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_owner,
    output logic [1:0] gnt
);
    always_comb gnt = (&req) ? ((last_owner == OWN_I) ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter: shares one AXI4 AR/R channel between the I-cache and D-cache miss FSMs.
// Define CACHE_RD_ARB_RR_EN for alternating tie priority; otherwise D always wins ties.
module cache_rd_arbiter
    import cache_axi_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter int         LINE_BEATS = 4,
    parameter logic [3:0] ID_I       = ID_I_DEF,
    parameter logic [3:0] ID_D       = ID_D_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_arvalid,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic              i_uncache,
    output logic              i_arready,
    output logic              i_rvalid,
    output logic              i_rlast,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              i_rready,
    input  logic              d_arvalid,
    input  logic [ADDR_W-1:0] d_araddr,
    input  logic              d_uncache,
    output logic              d_arready,
    output logic              d_rvalid,
    output logic              d_rlast,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              d_rready,
    output logic              m_arvalid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [3:0]        m_arid,
    input  logic              m_arready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rlast,
    output logic              m_rready,
    output logic              rlast_err
);
    logic [1:0]        state;
    owner_e            own_q;
    owner_e            last_own;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_win;
    logic [7:0]        len_q;
    logic [7:0]        cnt;
    logic [1:0]        gnt;
    logic              unc_win;
    logic              st_addr;
    logic              st_data;
    logic              own_d;
    logic              r_hs;

    cache_rd_arb_pick u_pick (
        .req        ({d_arvalid, i_arvalid}),
        .last_owner (last_own),
        .gnt        (gnt)
    );

`ifdef CACHE_RD_ARB_RR_EN
    owner_e last_q;
    // Only ties move the priority, so a lone requester never steals the next tie.
    always_ff @(posedge clk) begin
        if (!rstn)
            last_q <= OWN_I;
        else if (state == ST_IDLE && d_arvalid && i_arvalid)
            last_q <= gnt[1] ? OWN_D : OWN_I;
    end
    assign last_own = last_q;
`else
    assign last_own = OWN_I;
`endif

    assign addr_win = gnt[1] ? d_araddr : i_araddr;
    assign unc_win  = gnt[1] ? d_uncache : i_uncache;
    assign st_addr  = state == ST_ADDR;
    assign st_data  = state == ST_DATA;
    assign own_d    = own_q == OWN_D;
    assign r_hs     = m_rvalid && m_rready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            own_q     <= OWN_I;
            addr_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            rlast_err <= 1'b0;
        end else begin
            // Beat count is checked against the burst length but the FSM trusts m_rlast.
            rlast_err <= r_hs && (m_rlast != (cnt == len_q));
            case (state)
                ST_IDLE: if (|gnt) begin
                    state  <= ST_ADDR;
                    own_q  <= gnt[1] ? OWN_D : OWN_I;
                    addr_q <= addr_win & ~ADDR_W'(unc_win ? 4'h3 : 4'hF);
                    len_q  <= unc_win ? 8'd0 : 8'(LINE_BEATS - 1);
                end
                ST_ADDR: if (m_arready) begin
                    state <= ST_DATA;
                    cnt   <= '0;
                end
                ST_DATA: if (r_hs) begin
                    cnt <= cnt + 8'd1;
                    if (m_rlast) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_arvalid = st_addr;
    assign m_araddr  = st_addr ? addr_q : '0;
    assign m_arlen   = st_addr ? len_q : 8'd0;
    assign m_arid    = st_addr ? (own_d ? ID_D : ID_I) : 4'd0;
    assign m_arsize  = AXI_SIZE_4B;
    assign m_arburst = AXI_BURST_INCR;
    assign m_rready  = st_data && (own_d ? d_rready : i_rready);
    assign i_arready = st_addr && !own_d && m_arready;
    assign d_arready = st_addr && own_d && m_arready;
    assign i_rvalid  = st_data && !own_d && m_rvalid;
    assign d_rvalid  = st_data && own_d && m_rvalid;
    assign i_rlast   = i_rvalid && m_rlast;
    assign d_rlast   = d_rvalid && m_rlast;
    assign i_rdata   = (st_data && !own_d) ? m_rdata : '0;
    assign d_rdata   = (st_data && own_d) ? m_rdata : '0;
endmodule

// File: tb/tb_cache_rd_arbiter.sv
// tb_cache_rd_arbiter: scoreboard bench; stimulus pushes expected AR/R/error events, a negedge monitor pops and compares.
module tb_cache_rd_arbiter;
    logic        clk = 0, rstn = 0;
    logic        i_arvalid = 0, i_uncache = 0, i_rready = 1;
    logic        d_arvalid = 0, d_uncache = 0, d_rready = 1;
    logic [31:0] i_araddr = 0, d_araddr = 0, m_rdata = 0;
    logic        m_arready = 0, m_rvalid = 0, m_rlast = 0;
    logic        i_arready, i_rvalid, i_rlast, d_arready, d_rvalid, d_rlast;
    logic [31:0] i_rdata, d_rdata, m_araddr;
    logic        m_arvalid, m_rready, rlast_err;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [3:0]  m_arid;

    cache_rd_arbiter dut (
        .clk(clk), .rstn(rstn),
        .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_uncache(i_uncache), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata), .i_rready(i_rready),
        .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_uncache(d_uncache), .d_arready(d_arready),
        .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rdata(d_rdata), .d_rready(d_rready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arid(m_arid), .m_arready(m_arready), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rready(m_rready), .rlast_err(rlast_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic [7:0] len; logic [3:0] id;} ar_t;
    typedef struct {logic d; logic [31:0] data; logic last;} r_t;
    ar_t  ar_q[$];
    r_t   r_q[$];
    logic err_q[$];
    int   checks = 0, errors = 0;
    logic prev_hs = 0;
    logic first_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ar(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        ar_q.push_back(ar_t'{addr, len, id});
    endtask

    task automatic wait_ar(input string name);
        int t = 0;
        while (!m_arvalid && t < 20) begin
            tick();
            t++;
        end
        check({name, "_arvalid"}, 64'(m_arvalid), 64'd1);
    endtask

    // Hold m_arready low for `stall` cycles, then accept; the owner drops its request afterwards.
    task automatic ar_accept(input logic d, input int stall);
        logic [43:0] snap;
        snap = {m_araddr, m_arlen, m_arid};
        for (int s = 0; s < stall; s++) begin
            tick();
            check("ar_hold", {m_arvalid, m_araddr, m_arlen, m_arid, i_arready, d_arready, m_rready, i_rvalid, d_rvalid},
                  {1'b1, snap, 5'b0});
        end
        m_arready = 1;
        @(negedge clk);
        check("arready_route", {i_arready, d_arready}, d ? 64'b01 : 64'b10);
        tick();
        m_arready = 0;
        if (d) d_arvalid = 0;
        else i_arvalid = 0;
    endtask

    task automatic beats(input logic d, input int k0, input int k1, input int last_at, input int len, input logic [31:0] base);
        for (int k = k0; k < k1; k++) begin
            m_rvalid = 1;
            m_rdata  = base + 32'(k);
            m_rlast  = (k == last_at);
            r_q.push_back(r_t'{d, base + 32'(k), k == last_at});
            err_q.push_back((k == last_at) != (k == len));
            tick();
        end
        m_rvalid = 0;
        m_rlast  = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {m_arvalid, m_araddr, m_arlen, m_arid, m_rready, i_arready, i_rvalid, i_rlast,
                               d_arready, d_rvalid, d_rlast, rlast_err}, 64'd0);
        check({name, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
        check({name, "_const"}, {m_arsize, m_arburst}, 64'b010_01);
    endtask

    always @(negedge clk) begin
        ar_t  a;
        r_t   r;
        logic e, ds;
        if (prev_hs) begin
            if (err_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL err_q_underflow act=empty exp=entry");
            end else begin
                e = err_q.pop_front();
                if (rstn) check("rlast_err", 64'(rlast_err), 64'(e));
            end
        end else if (rstn && rlast_err) begin
            checks++; errors++;
            $display("FAIL rlast_err_spurious act=1 exp=0");
        end
        prev_hs = rstn && m_rvalid && m_rready;
        if (rstn && m_arvalid && m_arready) begin
            if (ar_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ar_unexpected act=%h exp=none", m_araddr);
            end else begin
                a = ar_q.pop_front();
                check("ar", {m_araddr, m_arlen, m_arid, m_arsize, m_arburst}, {a.addr, a.len, a.id, 3'b010, 2'b01});
            end
        end
        if (rstn && ((i_rvalid && i_rready) || (d_rvalid && d_rready))) begin
            ds = d_rvalid && d_rready;
            if (r_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL r_unexpected act=%h exp=none", ds ? d_rdata : i_rdata);
            end else begin
                r = r_q.pop_front();
                check("r_beat", {ds, ds ? d_rdata : i_rdata, ds ? d_rlast : i_rlast, ds ? i_rvalid : d_rvalid},
                      {r.d, r.data, r.last, 1'b0});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_rvalid = 1;
        tick();
        tick();
        check_reset_outputs("reset");
        m_rvalid = 0;
        rstn = 1;
        tick();

        // I-only cached line refill
        i_arvalid = 1; i_araddr = 32'h1C00_0014; i_uncache = 0;
        exp_ar(32'h1C00_0010, 8'd3, 4'd0);
        check("idle_arvalid", 64'(m_arvalid), 64'd0);
        tick();
        check("latency", 64'(m_arvalid), 64'd1);
        ar_accept(0, 0);
        beats(0, 0, 4, 3, 3, 32'hA0);
        check("idle_after_i", {m_arvalid, m_rready}, 64'd0);

        // D uncached single beat
        d_arvalid = 1; d_araddr = 32'h8000_0007; d_uncache = 1;
        exp_ar(32'h8000_0004, 8'd0, 4'd1);
        wait_ar("d_unc");
        ar_accept(1, 0);
        beats(1, 0, 1, 0, 0, 32'hB0);

        // Tie: D first, then I after one idle cycle
        i_arvalid = 1; i_araddr = 32'h0000_0100; i_uncache = 0;
        d_arvalid = 1; d_araddr = 32'h0000_0200; d_uncache = 0;
        exp_ar(32'h0000_0200, 8'd3, 4'd1);
        exp_ar(32'h0000_0100, 8'd3, 4'd0);
        wait_ar("tie1");
        ar_accept(1, 0);
        beats(1, 0, 4, 3, 3, 32'hC0);
        check("gap_idle", 64'(m_arvalid), 64'd0);
        tick();
        check("gap_end", 64'(m_arvalid), 64'd1);
        ar_accept(0, 0);
        beats(0, 0, 4, 3, 3, 32'hD0);

        // Second tie: round-robin hands it to I, fixed priority keeps D
`ifdef CACHE_RD_ARB_RR_EN
        first_d = 0;
`else
        first_d = 1;
`endif
        i_arvalid = 1; i_araddr = 32'h0000_0300; i_uncache = 1;
        d_arvalid = 1; d_araddr = 32'h0000_0404; d_uncache = 1;
        if (first_d) begin
            exp_ar(32'h0000_0404, 8'd0, 4'd1);
            exp_ar(32'h0000_0300, 8'd0, 4'd0);
        end else begin
            exp_ar(32'h0000_0300, 8'd0, 4'd0);
            exp_ar(32'h0000_0404, 8'd0, 4'd1);
        end
        wait_ar("tie2a");
        ar_accept(first_d, 0);
        beats(first_d, 0, 1, 0, 0, 32'hE0);
        wait_ar("tie2b");
        ar_accept(!first_d, 0);
        beats(!first_d, 0, 1, 0, 0, 32'hE8);

        // AR stall with a stray R beat that must not be taken
        d_arvalid = 1; d_araddr = 32'h3000_0008; d_uncache = 0;
        exp_ar(32'h3000_0000, 8'd3, 4'd1);
        wait_ar("stall");
        m_rvalid = 1; m_rdata = 32'h5555_5555;
        ar_accept(1, 5);
        m_rvalid = 0;
        beats(1, 0, 4, 3, 3, 32'hF0);

        // Owner rready low mid-burst, then early m_rlast on beat 3 of 4
        i_arvalid = 1; i_araddr = 32'h0000_0040; i_uncache = 0;
        exp_ar(32'h0000_0040, 8'd3, 4'd0);
        wait_ar("early");
        ar_accept(0, 0);
        beats(0, 0, 1, -1, 3, 32'h10);
        i_rready = 0; m_rvalid = 1; m_rdata = 32'hDEAD; m_rlast = 0;
        for (int s = 0; s < 2; s++) begin
            #1;
            check("stall_rready", {m_rready, i_rvalid}, 64'b01);
            tick();
        end
        i_rready = 1;
        beats(0, 1, 3, 2, 3, 32'h10);
        check("early_idle", {m_arvalid, m_rready}, 64'd0);

        // Count reaches ARLEN without m_rlast: error flagged, FSM waits for m_rlast
        d_arvalid = 1; d_araddr = 32'h0000_0500; d_uncache = 0;
        exp_ar(32'h0000_0500, 8'd3, 4'd1);
        wait_ar("late");
        ar_accept(1, 0);
        beats(1, 0, 5, 4, 3, 32'h20);
        check("late_idle", {m_arvalid, m_rready}, 64'd0);

        // Reset during beat 2 of a refill
        i_arvalid = 1; i_araddr = 32'h0000_0600; i_uncache = 0;
        exp_ar(32'h0000_0600, 8'd3, 4'd0);
        wait_ar("rst");
        ar_accept(0, 0);
        beats(0, 0, 1, -1, 3, 32'h30);
        rstn = 0; m_rvalid = 1; m_rdata = 32'h31;
        tick();
        check_reset_outputs("midrst");
        rstn = 1; m_rvalid = 0;
        d_arvalid = 1; d_araddr = 32'h0000_0700; d_uncache = 1;
        exp_ar(32'h0000_0700, 8'd0, 4'd1);
        wait_ar("post_rst");
        ar_accept(1, 0);
        beats(1, 0, 1, 0, 0, 32'h40);

        tick();
        tick();
        check("ar_q_empty", 64'(ar_q.size()), 64'd0);
        check("r_q_empty", 64'(r_q.size()), 64'd0);
        check("err_q_empty", 64'(err_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
